// File: rtl/firebird7_scanmux_pkg.sv
// Shared definitions for the secure n-way iJTAG scan mux:
// width derivation helpers, default unlock key, lock-state encoding.
package firebird7_scanmux_pkg;

    localparam logic [7:0] DEFAULT_UNLOCK_KEY = 8'hA5;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_e;

    // Select-field width; a 2-way mux still needs one select bit.
    function automatic int sel_w_of(input int num_in);
        return (num_in > 2) ? $clog2(num_in) : 1;
    endfunction

    // Shift-register width: the key field sits above the select field.
    function automatic int sr_w_of(input int sel_w, input int key_w, input bit lock_en);
        return lock_en ? (sel_w + key_w) : sel_w;
    endfunction

endpackage

// File: rtl/firebird7_scanmux_onehot_dec.sv
// Shadow-select to one-hot downstream segment enable decoder.
// Enables are gated by the segment select so idle segments see all zeros.
module firebird7_scanmux_onehot_dec #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic              en,
    input  logic [SEL_W-1:0]  shadow,
    output logic [NUM_IN-1:0] onehot
);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_dec
        assign onehot[i] = en && (shadow == SEL_W'(i));
    end

endmodule

// File: rtl/firebird7_in_gate2_tessent_scanmux_nway_secure.sv
// Secure n-way iJTAG scan mux (SIB-style select register with shadow).
// Optional key lock compiled in with macro FIREBIRD7_SCANMUX_LOCK_EN:
// the select register grows by a key field, wrong keys force select 0,
// and the third wrong key latches lockout until reset.
module firebird7_in_gate2_tessent_scanmux_nway_secure
    import firebird7_scanmux_pkg::*;
#(
    parameter int              NUM_IN     = 4,
    parameter int              SEL_W      = sel_w_of(NUM_IN),
    parameter int              KEY_W      = 8,
    parameter logic [KEY_W-1:0] UNLOCK_KEY = KEY_W'(DEFAULT_UNLOCK_KEY)
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ijtag_sel,
    input  logic              ijtag_se,
    input  logic              ijtag_ce,
    input  logic              ijtag_ue,
    input  logic              ijtag_si,
    output logic              ijtag_so,
    input  logic [NUM_IN-1:0] mux_in,
    output logic              mux_out,
    output logic [NUM_IN-1:0] enable_out,
    output logic [SEL_W-1:0]  sel_value,
    output logic              locked,
    output logic              lockout
);

`ifdef FIREBIRD7_SCANMUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int SR_W = sr_w_of(SEL_W, KEY_W, LOCK_EN);

    logic [SR_W-1:0]  sr;
    logic [SR_W:0]    sr_shifted;
    logic [SEL_W-1:0] shadow;
    logic [SEL_W-1:0] sel_field;
    logic [31:0]      sel_ext;
    logic             in_range;
    logic             do_shift;
    logic             do_capture;
    logic             do_update;

    // se > ce > ue priority; nothing moves while the segment is deselected.
    assign do_shift   = ijtag_sel && ijtag_se;
    assign do_capture = ijtag_sel && ijtag_ce && !ijtag_se;
    assign do_update  = ijtag_sel && ijtag_ue && !ijtag_se && !ijtag_ce;

    assign sr_shifted = {ijtag_si, sr};
    assign sel_field  = sr[SEL_W-1:0];
    assign sel_ext    = 32'(sel_field);
    assign in_range   = sel_ext < 32'(NUM_IN);

    // Select register: shift right with scan-in at MSB; capture reloads the
    // shadow into the select field and clears any key bits above it.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset)
            sr <= '0;
        else if (do_shift)
            sr <= sr_shifted[SR_W:1];
        else if (do_capture)
            sr <= SR_W'(shadow);
    end

`ifdef FIREBIRD7_SCANMUX_LOCK_EN
    logic [KEY_W-1:0] key_field;
    logic [1:0]       bad_cnt;
    lock_state_e      lock_state;
    logic             locked_q;
    logic             lockout_q;

    assign key_field = sr[SR_W-1:SEL_W];

    // Lock FSM and shadow: correct key unlocks, wrong key while locked forces
    // select 0 and counts; the third miss is terminal until reset.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            shadow     <= '0;
            bad_cnt    <= 2'd0;
            lock_state <= LOCKED;
            locked_q   <= 1'b1;
            lockout_q  <= 1'b0;
        end else if (do_update) begin
            case (lock_state)
                LOCKOUT: begin
                    shadow <= '0;
                end
                LOCKED: begin
                    if (key_field == UNLOCK_KEY) begin
                        lock_state <= UNLOCKED;
                        locked_q   <= 1'b0;
                        if (in_range)
                            shadow <= sel_field;
                    end else begin
                        shadow  <= '0;
                        bad_cnt <= bad_cnt + 2'd1;
                        if (bad_cnt == 2'd2) begin
                            lock_state <= LOCKOUT;
                            lockout_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (in_range)
                        shadow <= sel_field;
                end
            endcase
        end
    end

    assign locked  = locked_q;
    assign lockout = lockout_q;
`else
    logic unused_key;
    assign unused_key = ^UNLOCK_KEY;

    // Shadow: take any in-range select on update, reject out-of-range codes.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset)
            shadow <= '0;
        else if (do_update && in_range)
            shadow <= sel_field;
    end

    assign locked  = 1'b0;
    assign lockout = 1'b0;
`endif

    assign ijtag_so  = sr[0];
    assign sel_value = shadow;
    assign mux_out   = mux_in[shadow];

    firebird7_scanmux_onehot_dec #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_dec (
        .en     (ijtag_sel),
        .shadow (shadow),
        .onehot (enable_out)
    );

endmodule

// File: tb/tb_firebird7_in_gate2_tessent_scanmux_nway_secure.sv
// Bench for the secure scan mux (NUM_IN=5, SEL_W=3, KEY_W=8). Lock-specific
// scenarios run only when FIREBIRD7_SCANMUX_LOCK_EN is defined.
module tb_firebird7_in_gate2_tessent_scanmux_nway_secure;

    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;
    localparam int KEY_W  = 8;
`ifdef FIREBIRD7_SCANMUX_LOCK_EN
    localparam bit LOCK = 1'b1;
    localparam int SR_W = SEL_W + KEY_W;
`else
    localparam bit LOCK = 1'b0;
    localparam int SR_W = SEL_W;
`endif

    logic              ijtag_tck = 1'b0;
    logic              ijtag_reset = 1'b1;
    logic              ijtag_sel = 1'b0;
    logic              ijtag_se = 1'b0;
    logic              ijtag_ce = 1'b0;
    logic              ijtag_ue = 1'b0;
    logic              ijtag_si = 1'b0;
    logic              ijtag_so;
    logic [NUM_IN-1:0] mux_in = 5'b00110;
    logic              mux_out;
    logic [NUM_IN-1:0] enable_out;
    logic [SEL_W-1:0]  sel_value;
    logic              locked;
    logic              lockout;

    int total = 0;
    int bad = 0;

    firebird7_in_gate2_tessent_scanmux_nway_secure #(
        .NUM_IN     (NUM_IN),
        .SEL_W      (SEL_W),
        .KEY_W      (KEY_W),
        .UNLOCK_KEY (8'hA5)
    ) dut (
        .ijtag_tck   (ijtag_tck),
        .ijtag_reset (ijtag_reset),
        .ijtag_sel   (ijtag_sel),
        .ijtag_se    (ijtag_se),
        .ijtag_ce    (ijtag_ce),
        .ijtag_ue    (ijtag_ue),
        .ijtag_si    (ijtag_si),
        .ijtag_so    (ijtag_so),
        .mux_in      (mux_in),
        .mux_out     (mux_out),
        .enable_out  (enable_out),
        .sel_value   (sel_value),
        .locked      (locked),
        .lockout     (lockout)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int m_sr = 0, m_shadow = 0, m_bad = 0, m_sf = 0, m_key = 0;
    bit m_locked = 1'b0, m_lockout = 1'b0;

    always @(posedge ijtag_tck) begin
        m_sf  = m_sr % (1 << SEL_W);
        m_key = m_sr / (1 << SEL_W);
        if (ijtag_reset) begin
            m_sr = 0; m_shadow = 0; m_bad = 0; m_lockout = 1'b0; m_locked = LOCK;
        end else if (ijtag_sel) begin
            if (ijtag_se)
                m_sr = m_sr / 2 + (ijtag_si ? (1 << (SR_W - 1)) : 0);
            else if (ijtag_ce)
                m_sr = m_shadow;
            else if (ijtag_ue) begin
                if (m_lockout)
                    m_shadow = 0;
                else if (m_locked && m_key != 'hA5) begin
                    m_shadow = 0;
                    m_bad++;
                    if (m_bad == 3) m_lockout = 1'b1;
                end else begin
                    m_locked = 1'b0;
                    if (m_sf < NUM_IN) m_shadow = m_sf;
                end
            end
        end
        #1;
        check("so",       32'(ijtag_so),   32'(m_sr % 2));
        check("sel_value",32'(sel_value),  32'(m_shadow));
        check("enable",   32'(enable_out), ijtag_sel ? (32'd1 << m_shadow) : 32'd0);
        check("mux_out",  32'(mux_out),    32'((mux_in >> m_shadow) & 1));
        check("locked",   32'(locked),     32'(m_locked));
        check("lockout",  32'(lockout),    32'(m_lockout));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge ijtag_tck);
        mux_in = {mux_in[3:0], ~mux_in[4]};
        #1;
    endtask

    task automatic drive(input logic sel, se, ce, ue, si);
        ijtag_sel = sel; ijtag_se = se; ijtag_ce = ce; ijtag_ue = ue; ijtag_si = si;
    endtask

    task automatic shift_upd(input logic [7:0] key, input logic [2:0] s);
        logic [10:0] v;
        v = {key, s};
        for (int i = 0; i < SR_W; i++) begin
            drive(1, 1, 0, 0, v[i]);
            step();
        end
        drive(1, 0, 0, 1, 0);
        step();
        drive(1, 0, 0, 0, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] so_exp;
        // reset
        drive(0, 0, 0, 0, 0);
        ijtag_reset = 1'b1;
        step(); step();
        ijtag_reset = 1'b0;
        drive(1, 0, 0, 0, 0);
        step();
        check("rst_sel", 32'(sel_value), 32'd0);
        check("rst_locked", 32'(locked), 32'(LOCK));
        check("rst_lockout", 32'(lockout), 32'd0);
        check("rst_enable", 32'(enable_out), 32'h01);

        // correct key + select 2 (unlocks when lock is built in)
        shift_upd(8'hA5, 3'd2);
        step();
        check("unlock_sel", 32'(sel_value), 32'd2);
        check("unlock_locked", 32'(locked), 32'd0);

        // select 3
        shift_upd(8'hA5, 3'd3);
        step();
        check("sel3", 32'(sel_value), 32'd3);
        check("sel3_en", 32'(enable_out), 32'b01000);
        mux_in = 5'b01000; #1;
        check("sel3_mux_hi", 32'(mux_out), 32'd1);
        mux_in = 5'b10111; #1;
        check("sel3_mux_lo", 32'(mux_out), 32'd0);

        // out-of-range select 6 rejected
        shift_upd(8'hA5, 3'd6);
        step();
        check("reject6", 32'(sel_value), 32'd3);

        // se+ue together: shift wins; so shows prior contents LSB-first (0,1,1)
        so_exp = 3'b110;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, i[0] ? 1'b0 : 1'b1);
            check("se_ue_so", 32'(ijtag_so), 32'(so_exp[i]));
            step();
        end
        drive(1, 0, 0, 0, 0);
        check("se_ue_hold", 32'(sel_value), 32'd3);
        // select field is now 5 (== NUM_IN): boundary reject
        drive(1, 0, 0, 1, 0); step(); drive(1, 0, 0, 0, 0);
        check("reject5", 32'(sel_value), 32'd3);

        // highest legal select
        shift_upd(8'hA5, 3'd4);
        step();
        check("sel4", 32'(sel_value), 32'd4);
        check("sel4_en", 32'(enable_out), 32'b10000);

        // capture with ue also high: capture wins, shadow reloads select field
        drive(1, 0, 1, 1, 0); step();
        so_exp = 3'b100;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0);
            check("cap_so", 32'(ijtag_so), 32'(so_exp[i]));
            step();
        end

        // deselected: everything holds, enables gated off
        drive(0, 1, 0, 1, 1); step(); step();
        check("desel_en", 32'(enable_out), 32'd0);
        check("desel_sel", 32'(sel_value), 32'd4);

        // reset in the middle of a shift
        drive(1, 1, 0, 0, 1); step(); step();
        ijtag_reset = 1'b1; step();
        ijtag_reset = 1'b0; drive(1, 0, 0, 0, 0);
        check("midrst_sel", 32'(sel_value), 32'd0);
        check("midrst_so", 32'(ijtag_so), 32'd0);
        check("midrst_en", 32'(enable_out), 32'd1);
        check("midrst_locked", 32'(locked), 32'(LOCK));
        step();

`ifdef FIREBIRD7_SCANMUX_LOCK_EN
        // three wrong keys -> lockout; correct key afterwards is ignored
        for (int i = 0; i < 3; i++) begin
            shift_upd(8'h00, 3'd3);
            step();
            check("badkey_sel", 32'(sel_value), 32'd0);
            check("badkey_lockout", 32'(lockout), (i == 2) ? 32'd1 : 32'd0);
        end
        shift_upd(8'hA5, 3'd2);
        step();
        check("lockout_sel", 32'(sel_value), 32'd0);
        check("lockout_locked", 32'(locked), 32'd1);
        ijtag_reset = 1'b1; step(); ijtag_reset = 1'b0;
        check("lockout_clr", 32'(lockout), 32'd0);
        shift_upd(8'hA5, 3'd2);
        step();
        check("relock_sel", 32'(sel_value), 32'd2);
`endif

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
